// File: rtl/branch_predictor_if.sv
// Prediction/resolution bundle between fetch, execute and the branch predictor.
// Latency: n/a (signal bundle only).
// Backpressure: none; lookups and updates are fire-and-forget, one per cycle.
//
// Ports (predictor view, modport slave):
//   in : lu_valid, lu_pc, upd_valid, upd_pc, upd_taken, upd_target,
//        upd_mispredict, flush
//   out: pred_valid, pred_taken, pred_target, mispred_cnt
interface branch_predictor_if #(
  parameter int DataWidth = 32
);
  logic                 lu_valid;
  logic [DataWidth-1:0] lu_pc;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [DataWidth-1:0] pred_target;
  logic                 upd_valid;
  logic [DataWidth-1:0] upd_pc;
  logic                 upd_taken;
  logic [DataWidth-1:0] upd_target;
  logic                 upd_mispredict;
  logic                 flush;
  logic [31:0]          mispred_cnt;

  // Fetch/execute side.
  modport master (
    output lu_valid, lu_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_mispredict, flush,
    input  pred_valid, pred_taken, pred_target, mispred_cnt
  );

  // Predictor side.
  modport slave (
    input  lu_valid, lu_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_mispredict, flush,
    output pred_valid, pred_taken, pred_target, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and a mispredict counter.
// Latency: lookup result registered, valid exactly 1 cycle after lu_valid; updates land at the next edge.
// Backpressure: none; accepts one lookup and one update every cycle.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (table, pipeline and counter)
//   bp  - branch_predictor_if.slave: lookup request/result, execute resolution, flush, mispred_cnt
module branch_predictor #(
  parameter int DataWidth = 32,
  parameter int Entries   = 16
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagW = DataWidth - IdxW - 1;

  // Table state
  logic                 valid_q  [Entries];
  logic [TagW-1:0]      tag_q    [Entries];
  logic [DataWidth-1:0] target_q [Entries];
  logic [1:0]           ctr_q    [Entries];

  // Registered lookup result and mispredict counter
  logic                 pred_valid_q;
  logic                 pred_taken_q;
  logic [DataWidth-1:0] pred_target_q;
  logic [31:0]          mispred_cnt_q;

  // Bit 0 is a halfword offset and never participates in index or tag.
  logic unused_pc_lsb;
  assign unused_pc_lsb = bp.lu_pc[0] ^ bp.upd_pc[0];

  logic [IdxW-1:0] lu_idx;
  logic [TagW-1:0] lu_tag;
  logic [IdxW-1:0] upd_idx;
  logic [TagW-1:0] upd_tag;

  assign lu_idx  = bp.lu_pc[IdxW:1];
  assign lu_tag  = bp.lu_pc[DataWidth-1:IdxW+1];
  assign upd_idx = bp.upd_pc[IdxW:1];
  assign upd_tag = bp.upd_pc[DataWidth-1:IdxW+1];

  logic       lu_taken;
  logic       upd_hit;
  logic [1:0] upd_ctr_nxt;

  always_comb begin
    lu_taken    = 1'b0;
    upd_hit     = 1'b0;
    upd_ctr_nxt = ctr_q[upd_idx];

    // Reads see the table as of the start of the cycle (no write bypass).
    lu_taken = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag) && ctr_q[lu_idx][1];
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    if (bp.upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr_nxt = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr_nxt = ctr_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pred_valid_q  <= bp.lu_valid;
      pred_taken_q  <= bp.lu_valid && lu_taken;
      pred_target_q <= (bp.lu_valid && lu_taken) ? target_q[lu_idx] : '0;

      // Counts regardless of flush; sticks at all-ones.
      if (bp.upd_valid && bp.upd_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;

      // Flush wins over a same-cycle update, so an allocation cannot survive it.
      if (bp.flush) begin
        for (int i = 0; i < Entries; i++) valid_q[i] <= 1'b0;
      end else if (bp.upd_valid) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= upd_ctr_nxt;
          if (bp.upd_taken) target_q[upd_idx] <= bp.upd_target;
        end else if (bp.upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= bp.upd_target;
          ctr_q[upd_idx]    <= 2'b10;
        end
      end
    end
  end

  assign bp.pred_valid  = pred_valid_q;
  assign bp.pred_taken  = pred_taken_q;
  assign bp.pred_target = pred_target_q;
  assign bp.mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting beside the fetch stage. It supplies the predicted-taken flag and target that travel with each branch into execute. It also consumes execute's branch resolution (actual outcome, resolved target, mispredict flag) to train its table. This makes it the producing and consuming end of the prediction/resolution loop that execute closes.

## Interface
- `DataWidth`, 32, PC/target width.
- `Entries`, 16, table depth; power of two, ≥2. `IdxW` = log2(`Entries`).
- `clk` input 1 — sole clock, rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `lu_valid` input 1 — lookup request this cycle.
- `lu_pc` input DataWidth — PC to look up (halfword aligned, bit 0 ignored).
- `pred_valid` output 1 — prediction result valid.
- `pred_taken` output 1 — predicted taken.
- `pred_target` output DataWidth — predicted target; 0 when not taken.
- `upd_valid` input 1 — branch resolved in execute this cycle.
- `upd_pc` input DataWidth — PC of the resolved branch.
- `upd_taken` input 1 — actual outcome.
- `upd_target` input DataWidth — resolved target (pc + imm).
- `upd_mispredict` input 1 — execute flagged a mispredict; qualified by `upd_valid`.
- `flush` input 1 — invalidate the whole table (fence.i, context change).
- `mispred_cnt` output 32 — saturating mispredict count.

## Operation
- Index = `pc[IdxW:1]`. Tag = `pc[DataWidth-1:IdxW+1]`. Bit 0 is never used, so compressed halfword PCs map correctly.
- Each entry holds `valid`, `tag`, `target` (DataWidth), and `ctr` (2 bits).
- Reset value of every entry: `valid`=0, `tag`=0, `target`=0, `ctr`=2'b01.
- Hit = `valid` && tag match. Predicted taken = hit && `ctr[1]`.
- Lookup:
  - `lu_valid` in cycle N gives `pred_valid`=1 in N+1, with `pred_taken` and `pred_target` (entry target if taken, else 0).
  - `lu_valid`=0 in N gives `pred_valid`=0, `pred_taken`=0, `pred_target`=0 in N+1.
- Update on `upd_valid`, hit case:
  - `upd_taken`=1: `ctr` = min(`ctr`+1, 3) and `target` <= `upd_target`.
  - `upd_taken`=0: `ctr` = max(`ctr`-1, 0); `target` is unchanged.
  - The entry stays valid in both cases.
- Update on `upd_valid`, miss case:
  - `upd_taken`=1: allocate or overwrite the slot with `valid`=1, the new tag, `upd_target`, and `ctr`=2'b10.
  - `upd_taken`=0: no table change.
- `mispred_cnt` increments by 1 on `upd_valid && upd_mispredict`. It saturates at 32'hFFFF_FFFF, is not cleared by `flush`, and is cleared only by `rst`.
- `flush`: all `valid` bits clear at the next edge; `ctr`/`tag`/`target` need not be touched.

## Timing
- Lookup latency is exactly 1 cycle, fully pipelined, and accepts one request per cycle.
- Table writes take effect at the edge ending the update cycle. There is no write-to-read bypass: a lookup in cycle N observes table state as of the start of N, even if an update or flush to the same index happens in N.
- Simultaneous `flush` and `upd_valid`: `flush` wins and no allocation survives. `mispred_cnt` still counts the update.
- Simultaneous lookup and update to different indices are independent.
- Reset behaviour:
  - Reset values of all outputs: `pred_valid`=0, `pred_taken`=0, `pred_target`=0, `mispred_cnt`=0.
  - `rst` asserted mid-stream discards any lookup in flight; `pred_valid` is 0 in the cycle after `rst` is sampled.
  - The table returns to its reset state.
- No combinational path from any input to any output.

## Test plan
- Reset, then lookup 0x100 -> next cycle `pred_valid`=1, `pred_taken`=0, `pred_target`=0.
- Update pc 0x100 taken, target 0x80; lookup 0x100 one cycle later -> `pred_taken`=1, `pred_target`=0x80.
- Same-cycle update 0x100 taken and lookup 0x100 from a cold table -> this lookup returns not taken; the next lookup returns taken.
- Counter hysteresis at 0x100:
  - Three taken updates bring `ctr` to 3.
  - One not-taken update -> still taken.
  - A second not-taken update -> not taken, entry still valid.
  - One taken update -> taken again.
- Aliasing (`Entries`=16): 0x100 allocated taken; lookup 0x120 (same index 0, different tag) -> not taken. Taken update at 0x120 with target 0x40 -> 0x120 hits taken/0x40 and 0x100 now misses.
- `flush` plus taken update to 0x200 in the same cycle:
  - Lookups of 0x100 and 0x200 afterwards -> both not taken.
  - `upd_mispredict`=1 in that cycle -> `mispred_cnt` +1.
  - With the counter forced to the all-ones value, a further mispredict leaves it at 32'hFFFF_FFFF.
  - `rst` -> 0.
